// File: rtl/chess_mv_pkg.sv
// Shared move-slot layout, invalid-move constant and reader FSM states.
package chess_mv_pkg;

  localparam int unsigned MOVE_W   = 19;
  localparam int unsigned SLOTS    = 8;
  localparam int unsigned FlagsLsb = 12;
  localparam int unsigned FromLsb  = 6;
  localparam int unsigned ToLsb    = 0;

  localparam logic [MOVE_W-1:0] InvalidMove = {7'h40, 6'o00, 6'o00};

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StUnpk,
    StFin
  } state_e;

endpackage

// File: rtl/mv_slot_sel.sv
// Combinational slot mux: picks one packed move out of a FIFO word and splits its fields.
module mv_slot_sel #(
  parameter int unsigned SLOTS  = chess_mv_pkg::SLOTS,
  parameter int unsigned MOVE_W = chess_mv_pkg::MOVE_W
) (
  input  logic [SLOTS*MOVE_W-1:0]  word,
  input  logic [$clog2(SLOTS)-1:0] idx,
  output logic [6:0]               flags,
  output logic [5:0]               from,
  output logic [5:0]               to
);
  import chess_mv_pkg::*;

  logic [MOVE_W-1:0] slots [SLOTS];
  logic [MOVE_W-1:0] slot;

  // Slot 0 sits in the most significant bits, directly below the pad byte.
  for (genvar k = 0; k < SLOTS; k++) begin : g_slot
    assign slots[k] = word[SLOTS*MOVE_W-1-MOVE_W*k -: MOVE_W];
  end

  assign slot  = slots[idx];
  assign flags = slot[MOVE_W-1:FlagsLsb];
  assign from  = slot[FlagsLsb-1:FromLsb];
  assign to    = slot[FromLsb-1:ToLsb];

endmodule

// File: rtl/lmg_move_reader.sv
// Drains packed move words from the generator FIFO and hands them out one move at a time.
// Define LMG_MOVE_READER_SKIP_INV_EN to drop invalid (flags bit 6) slots instead of presenting them.
module lmg_move_reader #(
  parameter int unsigned WORD_W = 160,
  parameter int unsigned SLOTS  = chess_mv_pkg::SLOTS,
  parameter int unsigned MOVE_W = chess_mv_pkg::MOVE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              lmg_done,
  input  logic              fifo_empty,
  input  logic [WORD_W-1:0] fifo_q,
  output logic              fifo_rden,
  output logic              mv_valid,
  input  logic              mv_ready,
  output logic [6:0]        mv_flags,
  output logic [5:0]        mv_from,
  output logic [5:0]        mv_to,
  output logic [7:0]        move_count,
  output logic              done
);
  import chess_mv_pkg::*;

  localparam int unsigned IdxW  = $clog2(SLOTS);
  localparam int unsigned PackW = SLOTS * MOVE_W;

  state_e            state_q;
  logic [PackW-1:0]  word_q;
  logic [IdxW-1:0]   idx_q;
  logic [PackW-1:0]  sel_word;
  logic [IdxW-1:0]   sel_idx;
  logic [6:0]        sel_flags;
  logic [5:0]        sel_from;
  logic [5:0]        sel_to;
  logic              accept;
  logic              advance;
  logic              last_slot;
  logic              slot_ok;
  logic              unused_pad;

  assign unused_pad = ^fifo_q[WORD_W-1:PackW];

  assign fifo_rden = (state_q == StReq) && !fifo_empty;
  assign accept    = mv_valid && mv_ready;
  assign last_slot = (idx_q == IdxW'(SLOTS - 1));
  // An unpresented slot in UNPK is a skipped one and moves on without a handshake.
  assign advance   = (state_q == StUnpk) && (accept || !mv_valid);

  // In WAIT the mux looks at the incoming word so slot 0 is registered straight away.
  assign sel_word = (state_q == StWait) ? fifo_q[PackW-1:0] : word_q;
  assign sel_idx  = (state_q == StWait) ? '0 : idx_q + 1'b1;

`ifdef LMG_MOVE_READER_SKIP_INV_EN
  assign slot_ok = (sel_flags & InvalidMove[MOVE_W-1:FlagsLsb]) == '0;
`else
  assign slot_ok = 1'b1;
`endif

  mv_slot_sel #(
    .SLOTS  (SLOTS),
    .MOVE_W (MOVE_W)
  ) u_slot_sel (
    .word  (sel_word),
    .idx   (sel_idx),
    .flags (sel_flags),
    .from  (sel_from),
    .to    (sel_to)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      word_q     <= '0;
      idx_q      <= '0;
      mv_valid   <= 1'b0;
      mv_flags   <= '0;
      mv_from    <= '0;
      mv_to      <= '0;
      move_count <= '0;
      done       <= 1'b0;
    end else begin
      if (accept && move_count != 8'hFF) begin
        move_count <= move_count + 8'd1;
      end
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StReq;
            move_count <= '0;
          end
        end
        StReq: begin
          if (!fifo_empty) begin
            state_q <= StWait;
          end else if (lmg_done) begin
            state_q <= StFin;
            done    <= 1'b1;
          end
        end
        StWait: begin
          word_q   <= fifo_q[PackW-1:0];
          idx_q    <= '0;
          state_q  <= StUnpk;
          mv_valid <= slot_ok;
          mv_flags <= sel_flags;
          mv_from  <= sel_from;
          mv_to    <= sel_to;
        end
        StUnpk: begin
          if (advance) begin
            if (last_slot) begin
              state_q  <= StReq;
              mv_valid <= 1'b0;
              mv_flags <= '0;
              mv_from  <= '0;
              mv_to    <= '0;
            end else begin
              idx_q    <= sel_idx;
              mv_valid <= slot_ok;
              mv_flags <= sel_flags;
              mv_from  <= sel_from;
              mv_to    <= sel_to;
            end
          end
        end
        StFin: begin
          if (start) begin
            state_q    <= StReq;
            move_count <= '0;
            done       <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/lmg_move_reader.md
LMG_MOVE_READER -- requirements
Module: lmg_move_reader

Interface
REQ-001 SHALL have parameter WORD_W, default 160, meaning the FIFO word width (8 pad bits plus 8 packed move slots).
REQ-002 SHALL have parameter SLOTS, default 8, meaning the number of move slots per word.
REQ-003 SHALL have parameter MOVE_W, default 19, meaning the slot width: flags[18:12], from[11:6], to[5:0].
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: one-cycle pulse that begins draining the move FIFO.
REQ-007 SHALL have port lmg_done, input, 1 bit: the move generator has written its last word.
REQ-008 SHALL have port fifo_empty, input, 1 bit: the move FIFO is empty.
REQ-009 SHALL have port fifo_q, input, WORD_W bits: FIFO read data, valid one cycle after fifo_rden.
REQ-010 SHALL have port fifo_rden, output, 1 bit: FIFO read request.
REQ-011 SHALL have port mv_valid, output, 1 bit: a move is presented.
REQ-012 SHALL have port mv_ready, input, 1 bit: the consumer accepts the move.
REQ-013 SHALL have ports mv_flags (output, 7 bits), mv_from (output, 6 bits) and mv_to (output, 6 bits): fields of the presented move.
REQ-014 SHALL have port move_count, output, 8 bits: moves accepted since start.
REQ-015 SHALL have port done, output, 1 bit: all moves delivered.

Function
REQ-016 SHALL implement the states IDLE, REQ, WAIT, UNPK and FIN in one registered state machine.
REQ-017 IDLE SHALL go to REQ when start=1; start SHALL be ignored in every other state except FIN.
REQ-018 REQ SHALL drive fifo_rden=1 combinationally when fifo_empty=0, then go to WAIT.
REQ-019 REQ with fifo_empty=1 and lmg_done=0 SHALL hold fifo_rden=0 and stay in REQ.
REQ-020 REQ with fifo_empty=1 and lmg_done=1 SHALL go to FIN.
REQ-021 WAIT SHALL latch fifo_q into a word register, clear the slot index to 0 and go to UNPK.
REQ-022 Slot k SHALL occupy fifo_q[151-19k -: 19]; slot 0 is the first move delivered; bits [159:152] SHALL be ignored.
REQ-023 UNPK SHALL present slot[index] on mv_flags/mv_from/mv_to with mv_valid=1.
REQ-024 UNPK SHALL advance the index on mv_valid&&mv_ready; after index 7 advances, the state SHALL go to REQ.
REQ-025 While mv_valid=1 and mv_ready=0, the move outputs SHALL stay stable.
REQ-026 move_count SHALL increment on each accepted move and saturate at 255.
REQ-027 FIN SHALL hold done=1 and mv_valid=0; start in FIN SHALL clear move_count and done and go to REQ.
REQ-028 First mv_valid SHALL occur exactly 3 cycles after start is sampled when the FIFO is non-empty.

Reset
REQ-029 While reset=1: state=IDLE, fifo_rden=0, mv_valid=0, mv_flags/mv_from/mv_to=0, move_count=0, done=0.
REQ-030 A reset during WAIT or UNPK SHALL discard the latched word without further FIFO reads.

Configuration
REQ-031 With macro LMG_MOVE_READER_SKIP_INV_EN defined, a slot with flags bit 6 set (invalid move, 7'h40) SHALL be skipped in one cycle with mv_valid=0, and SHALL NOT be counted.
REQ-032 Without LMG_MOVE_READER_SKIP_INV_EN, every slot SHALL be presented with its flags unchanged.

Structure
REQ-033 Package chess_mv_pkg SHALL hold MOVE_W, SLOTS, the invalid-move constant {7'h40, 6'o00, 6'o00}, the slot field offsets and the state enum.
REQ-034 Sub-module mv_slot_sel SHALL implement the combinational 8:1 19-bit slot mux with field split.

Verification
REQ-035 Word with slot k = {7'd0, from=8k+1, to=8k+2}, mv_ready tied 1 -> 8 consecutive moves o01->o02 ... o71->o72, move_count=8.
REQ-036 Word with slots 4..7 flags=7'h40, macro defined -> 4 moves delivered, move_count=4; macro undefined -> 8 moves, slots 4..7 with mv_flags=7'h40.
REQ-037 mv_ready low for 5 cycles on slot 2 -> mv_valid held, o21->o22 stable, no index advance, no extra fifo_rden.
REQ-038 fifo_empty=1 and lmg_done=0 for 10 cycles, then lmg_done=1 -> fifo_rden never asserted, done=1 one cycle after lmg_done, move_count=0.
REQ-039 reset asserted on slot 3 of word 1 of 3 -> all outputs 0 immediately; start after release -> reading resumes with FIFO word 2.
